// File: rtl/cnn_ctrl_pkg.sv
// Shared control types for the CNN datapath sequencers.
// Holds the sequencer state encoding and the count clamp helper.
package cnn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Over-range requests saturate to the largest supported job.
  function automatic int clamp_count(
    input int cnt,
    input int max_cnt
  );
    return (cnt > max_cnt) ? max_cnt : cnt;
  endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable decrementing register with a zero flag.
// Clear beats load, load beats decrement; it never wraps below 0.
module down_counter #(
  parameter int NUM_COUNT     = 16,
  parameter int COUNTER_WIDTH = $clog2(NUM_COUNT + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [COUNTER_WIDTH-1:0] load_val,
  input  logic                     dec,
  input  logic                     clear,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic                     zero
);

  localparam logic [COUNTER_WIDTH-1:0] MaxVal =
    COUNTER_WIDTH'(NUM_COUNT);

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/countdown_sequencer.sv
// Drains a loaded step count over a valid/ready stream, counting down.
// Pulses done after the last step; abort returns to idle silently.
module countdown_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int NUM_COUNT     = 16,
  parameter int COUNTER_WIDTH = $clog2(NUM_COUNT + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_vld,
  output logic                     load_rdy,
  input  logic [COUNTER_WIDTH-1:0] load_count,
  input  logic                     abort,
  output logic                     step_vld,
  input  logic                     step_rdy,
  output logic [COUNTER_WIDTH-1:0] step_idx,
  output logic                     step_last,
  output logic                     busy,
  output logic                     done
);

  seq_state_t               state_q, state_d;
  logic [COUNTER_WIDTH-1:0] n_eff;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic                     cnt_zero;
  logic                     cnt_load;
  logic                     cnt_dec;

  assign n_eff = COUNTER_WIDTH'(
    clamp_count(int'(load_count), NUM_COUNT));

  always_comb begin
    state_d  = state_q;
    load_rdy = 1'b0;
    step_vld = 1'b0;
    done     = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        load_rdy = !abort;
        if (load_vld && !abort) begin
          if (n_eff == '0) begin
            state_d = DONE;
          end else begin
            state_d  = RUN;
            cnt_load = 1'b1;
          end
        end
      end
      RUN: begin
        step_vld = 1'b1;
        if (step_rdy) begin
          if (cnt_zero) begin
            state_d = DONE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a coinciding handshake.
    if (abort) begin
      state_d  = IDLE;
      done     = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  down_counter #(
    .NUM_COUNT    (NUM_COUNT),
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .load_val(n_eff - COUNTER_WIDTH'(1)),
    .dec     (cnt_dec),
    .clear   (abort),
    .count   (cnt),
    .zero    (cnt_zero)
  );

  assign step_idx  = cnt;
  assign step_last = step_vld && cnt_zero;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed and random checks of countdown_sequencer.
// Expected values come from a queue of outstanding step indices.
module tb_countdown_sequencer;

  localparam int NC = 16;
  localparam int W  = $clog2(NC + 1);

  logic         clk = 1'b0;
  logic         reset;
  logic         load_vld;
  logic         load_rdy;
  logic [W-1:0] load_count;
  logic         abort;
  logic         step_vld;
  logic         step_rdy;
  logic [W-1:0] step_idx;
  logic         step_last;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;
  int q[$];
  bit done_now;

  always #5 clk = ~clk;

  countdown_sequencer #(.NUM_COUNT(NC)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_vld  (load_vld),
    .load_rdy  (load_rdy),
    .load_count(load_count),
    .abort     (abort),
    .step_vld  (step_vld),
    .step_rdy  (step_rdy),
    .step_idx  (step_idx),
    .step_last (step_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_vld", 32'(step_vld), 0);
    check("rst_idx", 32'(step_idx), 0);
    check("rst_last", 32'(step_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
  endtask

  // One cycle: drive at negedge, check, advance model, pass the edge.
  task automatic step(input bit lv, input int lc,
                      input bit ab, input bit sr);
    bit e_vld, e_busy, e_lrdy, acc, hs, nd;
    int e_idx, n;
    load_vld   = lv;
    load_count = W'(lc);
    abort      = ab;
    step_rdy   = sr;
    #1;
    e_vld  = (q.size() > 0);
    e_idx  = e_vld ? q[0] : 0;
    e_busy = e_vld || done_now;
    e_lrdy = !e_busy && !ab;
    check("step_vld", 32'(step_vld), 32'(e_vld));
    check("step_idx", 32'(step_idx), 32'(e_idx));
    check("step_last", 32'(step_last), 32'(e_vld && e_idx == 0));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(done_now && !ab));
    check("load_rdy", 32'(load_rdy), 32'(e_lrdy));
    acc = lv && e_lrdy;
    hs  = e_vld && sr;
    nd  = 1'b0;
    if (ab) begin
      q.delete();
    end else begin
      if (hs) begin
        void'(q.pop_front());
        if (q.size() == 0) nd = 1'b1;
      end
      if (acc) begin
        n = (lc > NC) ? NC : lc;
        if (n == 0) nd = 1'b1;
        for (int i = n - 1; i >= 0; i--) q.push_back(i);
      end
    end
    done_now = nd;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    load_vld = 1'b0;
    load_count = '0;
    abort = 1'b0;
    step_rdy = 1'b0;
    done_now = 1'b0;
    #12;
    check_reset_vals();
    @(negedge clk);
    reset = 1'b1;

    step(1, 4, 0, 1);
    repeat (6) step(0, 0, 0, 1);

    step(1, 5, 0, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, (i % 2) == 1);

    step(1, 0, 0, 1);
    repeat (3) step(0, 0, 0, 1);

    step(1, 31, 0, 1);
    repeat (19) step(0, 0, 0, 1);

    step(1, 6, 0, 1);
    repeat (3) step(0, 0, 0, 1);
    check("abort_at_idx", 32'(step_idx), 2);
    step(0, 0, 1, 1);
    repeat (2) step(0, 0, 0, 1);
    step(1, 3, 1, 0);
    repeat (2) step(0, 0, 0, 0);

    step(1, 8, 0, 1);
    repeat (2) step(0, 0, 0, 1);
    #3 reset = 1'b0;
    #1;
    check_reset_vals();
    q.delete();
    done_now = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(1, 2, 0, 1);
    repeat (4) step(0, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 3) == 0,
           int'($urandom_range(0, 20)),
           ($urandom % 25) == 0,
           ($urandom % 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_sequencer.md
# countdown_sequencer

Loadable down-counter sequencer that drains a requested step count over a valid/ready stream. It is the consuming counterpart of the free-running up `counter`. A controller hands it a count, and it issues that many steps with descending indices, honouring downstream backpressure. It then pulses `done` and returns to idle. It drives tile/row iteration in the CNN datapath wherever a loop must run a variable number of times and stall with the consumer.

## Interface
Parameters:
- `NUM_COUNT`, 16: maximum steps per load.
- `COUNTER_WIDTH`, `$clog2(NUM_COUNT+1)`: width of count/index; must hold `NUM_COUNT`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load_vld`  in  1  new count offered.
- `load_rdy`  out  1  sequencer can accept a count.
- `load_count`  in  COUNTER_WIDTH  number of steps requested.
- `abort`  in  1  cancel current job.
- `step_vld`  out  1  a step is presented.
- `step_rdy`  in  1  consumer takes the step.
- `step_idx`  out  COUNTER_WIDTH  remaining-steps index, counts down to 0.
- `step_last`  out  1  `step_idx == 0` while `step_vld`.
- `busy`  out  1  state is RUN or DONE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - `load_rdy = !abort`.
  - On `load_vld && load_rdy`, capture the effective count `n`.
  - `n = min(load_count, NUM_COUNT)`; an over-range value saturates to `NUM_COUNT`.
  - If `n == 0`, go to DONE with no steps issued.
  - Otherwise go to RUN with `step_idx = n-1`.
- RUN:
  - `step_vld = 1` and `load_rdy = 0`.
  - On a handshake with `step_idx != 0`, decrement `step_idx`.
  - On a handshake with `step_idx == 0`, go to DONE.
  - Without a handshake, `step_idx` holds.
- DONE:
  - `done = 1` for exactly one cycle, then go to IDLE.
  - `step_vld = 0`.
- `abort` has top priority in every state:
  - The next state is IDLE and `step_idx` clears to 0.
  - No `done` pulse is produced, and no load is accepted in that cycle.
  - A step handshake coinciding with `abort` counts as consumed, but it does not cause a `done`.
- `step_vld` and `step_idx` depend only on registered state, never combinationally on `step_rdy`.
- Index arithmetic is unsigned at `COUNTER_WIDTH`; no decrement ever occurs from 0.
- A new `load_vld` asserted while busy is ignored: `load_rdy` is low and the producer holds its request.

## Timing
- Values while `reset` is low, asynchronously: state IDLE, `step_idx=0`, `step_vld=0`, `step_last=0`, `busy=0`, `done=0`.
- `load_rdy=1` in IDLE, provided `abort` is low.
- Load at edge k gives `step_vld=1` in cycle k+1, with `step_idx=n-1`.
- With `step_rdy` held high, `n` steps occupy cycles k+1..k+n and `done` is high in cycle k+n+1.
- The earliest next load is accepted at edge k+n+2. Load-to-load throughput is therefore `n+2` cycles (2 cycles for `n=0`).
- `busy` is high from cycle k+1 through the `done` cycle inclusive.
- Each low cycle of `step_rdy` stretches RUN by one cycle.
- Reset asserted mid-RUN gives all outputs their reset values immediately. There is no `done` and no partial state after release.

## Structure
- Shared package `cnn_ctrl_pkg`:
  - State enum `seq_state_t` {IDLE, RUN, DONE}.
  - Helper function for the saturating count clamp.
- One natural sub-module, `down_counter`:
  - Loadable decrementing register with `load`, `dec` and `clear` inputs and a `zero` flag.
  - Same parameters as this block.
  - The FSM and the handshake logic live in the top.

## Test plan
- Reset, then load 4 with `step_rdy=1` -> `step_idx` reads 3,2,1,0 in consecutive cycles. `step_last` is high only at 0. `done` pulses exactly one cycle later, and `load_rdy` is back the cycle after that.
- Load 5 with `step_rdy` toggling 1,0,1,0... -> 5 handshakes with indices 4..0, and `idx` holds on every low-ready cycle. `done` follows the last handshake by 1 cycle.
- Load 0 -> no `step_vld`. `done` in the cycle after the load, `busy` high for that one cycle only.
- Load 31 with `NUM_COUNT=16` -> saturates: exactly 16 steps, first `step_idx=15`.
- `abort` at `step_idx=2` mid-RUN -> IDLE next cycle, `step_idx=0`, no `done`. `abort` together with `load_vld` in IDLE -> `load_rdy=0` and the load is not accepted.
- `reset` pulsed low mid-RUN, asynchronous to `clk` -> outputs go to reset values immediately. After release, a new load of 2 runs normally.
